// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encodings, light constants and default phase durations for the traffic-light controller.
// FLASH exists only when TLC_NIGHT_FLASH_EN is defined.
package tlc_pkg;
    localparam int D_T_MAIN_G = 10;
    localparam int D_T_SIDE_G = 5;
    localparam int D_T_YEL    = 2;
    localparam int D_T_ALLRED = 1;
    localparam int D_CNT_W    = 5;
    localparam logic [2:0] LIGHT_R   = 3'b100;
    localparam logic [2:0] LIGHT_Y   = 3'b010;
    localparam logic [2:0] LIGHT_G   = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;
    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        ALLR1  = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        ALLR2  = 3'd5
`ifdef TLC_NIGHT_FLASH_EN
        , FLASH = 3'd6
`endif
    } tlc_state_e;
    function automatic tlc_state_e next_state(tlc_state_e s);
        return (s == MAIN_G) ? MAIN_Y :
               (s == MAIN_Y) ? ALLR1  :
               (s == ALLR1)  ? SIDE_G :
               (s == SIDE_G) ? SIDE_Y :
               (s == SIDE_Y) ? ALLR2  : MAIN_G;
    endfunction
    // {main, side} lamp pattern for a normal sequencing state
    function automatic logic [5:0] lights_of(tlc_state_e s);
        return (s == MAIN_G) ? {LIGHT_G, LIGHT_R} :
               (s == MAIN_Y) ? {LIGHT_Y, LIGHT_R} :
               (s == SIDE_G) ? {LIGHT_R, LIGHT_G} :
               (s == SIDE_Y) ? {LIGHT_R, LIGHT_Y} : {LIGHT_R, LIGHT_R};
    endfunction
endpackage

// File: rtl/tick_edge_det.sv
// tick_edge_det: synchronises a divided clock level and emits a one-cycle pulse per rising edge.
// Stays disarmed until prev holds a synchronised sample, so a level already high at reset release gives no tick.
module tick_edge_det (
    input  logic clk_osc,
    input  logic RESET,
    input  logic div_clk,
    output logic tick
);
    logic       sync1, sync2, prev;
    logic [2:0] fill;
    always_ff @(posedge clk_osc or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            fill  <= '0;
        end else begin
            sync1 <= div_clk;
            sync2 <= sync1;
            prev  <= sync2;
            fill  <= {fill[1:0], 1'b1};
        end
    end
    assign tick = fill[2] & sync2 & ~prev;
endmodule

// File: rtl/tlc_phase_ctrl.sv
// tlc_phase_ctrl: traffic-light phase sequencer driven by 1 s ticks derived from slow_clk.
// TLC_NIGHT_FLASH_EN adds night_mode and the FLASH state.
module tlc_phase_ctrl
    import tlc_pkg::*;
#(
    parameter int T_MAIN_G = D_T_MAIN_G,
    parameter int T_SIDE_G = D_T_SIDE_G,
    parameter int T_YEL    = D_T_YEL,
    parameter int T_ALLRED = D_T_ALLRED,
    parameter int CNT_W    = D_CNT_W
) (
    input  logic             clk_osc,
    input  logic             RESET,
    input  logic             slow_clk,
    input  logic             side_req,
    input  logic             ped_req,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic             night_mode,
`endif
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             ped_walk,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase
);
    tlc_state_e       state, state_n;
    logic [CNT_W-1:0] remain_n;
    logic [2:0]       main_n, side_n;
    logic             walk_n, side_pend, ped_pend, side_pend_n, ped_pend_n, tick, go;

    tick_edge_det u_tick (.clk_osc(clk_osc), .RESET(RESET), .div_clk(slow_clk), .tick(tick));

    function automatic logic [CNT_W-1:0] dur_of(tlc_state_e s);
        return (s == MAIN_G) ? CNT_W'(T_MAIN_G - 1) :
               (s == SIDE_G) ? CNT_W'(T_SIDE_G - 1) :
               (s == MAIN_Y || s == SIDE_Y) ? CNT_W'(T_YEL - 1) : CNT_W'(T_ALLRED - 1);
    endfunction

    // main green only yields once its minimum has run out and someone is waiting
    assign go    = tick && remain == '0 && (state != MAIN_G || side_pend || ped_pend);
    assign phase = state;

    always_comb begin
        state_n     = state;
        remain_n    = remain;
        walk_n      = ped_walk;
        side_pend_n = side_pend | side_req;
        ped_pend_n  = ped_pend | ped_req;
        if (go) begin
            state_n  = next_state(state);
            remain_n = dur_of(state_n);
            walk_n   = state == ALLR1 && ped_pend;
            if (state == ALLR1) begin
                side_pend_n = side_req;
                ped_pend_n  = ped_req;
            end
        end else if (tick && remain != '0)
            remain_n = remain - 1'b1;
        {main_n, side_n} = lights_of(state_n);
`ifdef TLC_NIGHT_FLASH_EN
        if (tick && night_mode) begin
            state_n  = FLASH;
            remain_n = '0;
            walk_n   = 1'b0;
            main_n   = (state == FLASH && main_light == LIGHT_Y) ? LIGHT_OFF : LIGHT_Y;
            side_n   = (state == FLASH && side_light == LIGHT_R) ? LIGHT_OFF : LIGHT_R;
        end else if (state == FLASH && tick) begin
            state_n          = ALLR2;
            remain_n         = dur_of(ALLR2);
            walk_n           = 1'b0;
            {main_n, side_n} = lights_of(ALLR2);
        end else if (state == FLASH) begin
            main_n = main_light;
            side_n = side_light;
        end
        if (state == FLASH || state_n == FLASH) begin
            side_pend_n = 1'b0;
            ped_pend_n  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_osc or posedge RESET) begin
        if (RESET) begin
            state      <= MAIN_G;
            remain     <= CNT_W'(T_MAIN_G - 1);
            main_light <= LIGHT_G;
            side_light <= LIGHT_R;
            ped_walk   <= 1'b0;
            side_pend  <= 1'b0;
            ped_pend   <= 1'b0;
        end else begin
            state      <= state_n;
            remain     <= remain_n;
            main_light <= main_n;
            side_light <= side_n;
            ped_walk   <= walk_n;
            side_pend  <= side_pend_n;
            ped_pend   <= ped_pend_n;
        end
    end
endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// tb_tlc_phase_ctrl: randomized request stimulus checked against a tick-level phase model.
module tb_tlc_phase_ctrl;
    localparam int TM = 3, TS = 2, TY = 1, TA = 1, CW = 5;
    logic          clk_osc = 1'b0, RESET = 1'b1, slow_clk = 1'b1, side_req = 1'b0, ped_req = 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
    logic          night_mode = 1'b0;
`endif
    logic [2:0]    main_light, side_light, phase;
    logic          ped_walk;
    logic [CW-1:0] remain;
    int n_checks = 0, n_errors = 0;
    int m_phase, m_rem;
    bit m_side, m_ped, m_walk, m_fl;
    int dur[6]      = '{TM, TY, TA, TS, TY, TA};
    int main_tab[6] = '{1, 2, 4, 4, 4, 4};
    int side_tab[6] = '{4, 4, 4, 1, 2, 4};

    always #5 clk_osc = ~clk_osc;

    tlc_phase_ctrl #(.T_MAIN_G(TM), .T_SIDE_G(TS), .T_YEL(TY), .T_ALLRED(TA), .CNT_W(CW)) dut (
        .clk_osc(clk_osc), .RESET(RESET), .slow_clk(slow_clk), .side_req(side_req), .ped_req(ped_req),
`ifdef TLC_NIGHT_FLASH_EN
        .night_mode(night_mode),
`endif
        .main_light(main_light), .side_light(side_light), .ped_walk(ped_walk), .remain(remain), .phase(phase)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_rem = TM - 1; m_side = 0; m_ped = 0; m_walk = 0; m_fl = 0;
    endtask

    task automatic model_tick(input bit nm);
`ifdef TLC_NIGHT_FLASH_EN
        if (nm) begin
            m_fl = (m_phase == 6) ? !m_fl : 1'b1;
            m_phase = 6; m_rem = 0; m_walk = 0; m_side = 0; m_ped = 0;
            return;
        end
        if (m_phase == 6) begin
            m_phase = 5; m_rem = TA - 1;
            return;
        end
`else
        if (nm) $display("night stimulus ignored in this build");
`endif
        if (m_rem > 0) m_rem--;
        else if (m_phase != 0 || m_side || m_ped) begin
            m_phase = (m_phase + 1) % 6;
            m_rem   = dur[m_phase] - 1;
            m_walk  = (m_phase == 3) && m_ped;
            if (m_phase == 3) begin m_side = 0; m_ped = 0; end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".phase"}, phase, m_phase);
        check({tag, ".remain"}, remain, m_rem);
        check({tag, ".main"}, main_light, m_phase == 6 ? (m_fl ? 2 : 0) : main_tab[m_phase]);
        check({tag, ".side"}, side_light, m_phase == 6 ? (m_fl ? 4 : 0) : side_tab[m_phase]);
        check({tag, ".walk"}, ped_walk, m_walk);
    endtask

    // one slow_clk period: rise, let the tick settle, check, then optional request pulses
    task automatic do_period(input bit s, input bit p, input bit n);
        @(negedge clk_osc);
        slow_clk = 1'b1;
`ifdef TLC_NIGHT_FLASH_EN
        night_mode = n;
`endif
        model_tick(n);
        repeat (9) @(negedge clk_osc);
        check_all("period");
        @(negedge clk_osc);
        slow_clk = 1'b0; side_req = s; ped_req = p;
        if (s) m_side = 1;
        if (p) m_ped = 1;
        @(negedge clk_osc);
        side_req = 1'b0; ped_req = 1'b0;
        repeat (8) @(negedge clk_osc);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk_osc);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_osc);
            check_all("post_reset");
        end
        slow_clk = 1'b0;
        repeat (4) @(negedge clk_osc);
        repeat (10) do_period(0, 0, 0);
        do_period(1, 0, 0);
        repeat (6) do_period(0, 0, 0);
        do_period(0, 1, 0);
        repeat (8) do_period(0, 0, 0);
        for (int i = 0; i < 40; i++)
            do_period($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 0);
        for (int i = 0; i < 30 && m_phase != 3; i++) do_period(1, 0, 0);
        check("reach_side_g", phase, 3);
        @(posedge clk_osc);
        #2 RESET = 1'b1;
        model_reset();
        #1 check_all("async_reset");
        slow_clk = 1'b0;
        repeat (3) @(negedge clk_osc);
        RESET = 1'b0;
        repeat (5) @(negedge clk_osc);
        for (int i = 0; i < 12; i++)
            do_period($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 0);
`ifdef TLC_NIGHT_FLASH_EN
        for (int i = 0; i < 30 && m_phase != 3; i++) do_period(0, 1, 0);
        check("night_side_g", phase, 3);
        repeat (3) do_period(0, 0, 1);
        repeat (3) do_period(0, 0, 0);
        repeat (4) do_period($urandom_range(0, 1) == 0, 0, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
